fpm_scheduler: RTL and testbench

Two-requester scheduler for the shared single-precision floating-point multiplier. It accepts operand pairs from two independent requesters over valid/ready handshakes and arbitrates between them round-robin. It holds the selected operands stable on the combinational multiplier core for a fixed multicycle window, then registers the product with a requester tag and status flags. It sits between the two issuing units and the one multiplier instance, so the long Wallace-tree path is a multicycle path rather than a single-cycle one.

---
 rtl/fpm_pkg.sv | 30 +++
 rtl/fp_mul32.sv | 71 +++++++
 rtl/fpm_scheduler.sv | 115 +++++++++++
 tb/tb_fpm_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpm_pkg.sv
// Shared types, field positions and flag decode for the fpm_scheduler slice.
package fpm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;
    localparam int MAN_LSB  = 0;

    localparam logic [7:0]  EXP_ALL1    = 8'hFF;
    localparam logic [31:0] FP_NAN_ALL1 = 32'hFFFF_FFFF;

    // Returns {nan, inf, zero}; the all-ones NaN code decodes as nan.
    function automatic logic [2:0] fp_flags(input logic [31:0] v);
        logic [7:0]  e;
        logic [22:0] m;
        e = v[EXP_MSB:EXP_LSB];
        m = v[MAN_MSB:MAN_LSB];
        fp_flags = {(e == EXP_ALL1) && (m != 23'd0),
                    (e == EXP_ALL1) && (m == 23'd0),
                    (e == 8'h00)    && (m == 23'd0)};
    endfunction

endpackage

// File: rtl/fp_mul32.sv
// Combinational IEEE-754 single multiplier core, round-to-nearest-even.
// Latency: none (pure combinational, meant to be used as a multicycle path).
// Backpressure: n/a. Subnormal operands/results flush to signed zero.
module fp_mul32
    import fpm_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    logic        sgn;
    logic [7:0]  ea, eb, e_res;
    logic [22:0] ma, mb, frac;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic [47:0] sig_a, sig_b, prod;
    logic        grd, stk, adj, rnd;
    logic [23:0] frac_r;
    logic [9:0]  e_sum;

    always_comb begin
        sgn    = a[SIGN_BIT] ^ b[SIGN_BIT];
        ea     = a[EXP_MSB:EXP_LSB];
        eb     = b[EXP_MSB:EXP_LSB];
        ma     = a[MAN_MSB:MAN_LSB];
        mb     = b[MAN_MSB:MAN_LSB];
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == EXP_ALL1) && (ma == 23'd0);
        b_inf  = (eb == EXP_ALL1) && (mb == 23'd0);
        a_nan  = (ea == EXP_ALL1) && (ma != 23'd0);
        b_nan  = (eb == EXP_ALL1) && (mb != 23'd0);

        sig_a = {24'd0, 1'b1, ma};
        sig_b = {24'd0, 1'b1, mb};
        prod  = sig_a * sig_b;

        // Product of two [1,2) significands lies in [1,4); normalise by one bit.
        if (prod[47]) begin
            frac = prod[46:24];
            grd  = prod[23];
            stk  = |prod[22:0];
            adj  = 1'b1;
        end else begin
            frac = prod[45:23];
            grd  = prod[22];
            stk  = |prod[21:0];
            adj  = 1'b0;
        end
        rnd    = grd & (stk | frac[0]);
        frac_r = {1'b0, frac} + {23'd0, rnd};

        // e_sum carries the doubled bias; result exponent is e_sum - 127.
        e_sum = {2'b00, ea} + {2'b00, eb} + {9'd0, adj} + {9'd0, frac_r[23]};
        e_res = e_sum[7:0] - 8'd127;

        p = {sgn, e_res, frac_r[22:0]};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            p = FP_NAN_ALL1;
        end else if (a_inf || b_inf) begin
            p = {sgn, EXP_ALL1, 23'd0};
        end else if (a_zero || b_zero) begin
            p = {sgn, 31'd0};
        end else if (e_sum >= 10'd382) begin
            p = {sgn, EXP_ALL1, 23'd0};
        end else if (e_sum <= 10'd127) begin
            p = {sgn, 31'd0};
        end
    end

endmodule

// File: rtl/fpm_scheduler.sv
// Round-robin scheduler for two requesters sharing one fp_mul32 core.
// Latency: accept at T, res_valid at T+MUL_CYCLES+1; one op in flight.
// Backpressure: res_ready low holds DONE and all outputs; req_ready stays 0.
module fpm_scheduler
    import fpm_pkg::*;
#(
    parameter int MUL_CYCLES = 2
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_id,
    output logic [2:0]  res_flags,
    output logic [15:0] op_count
);

    localparam logic [3:0] CNT_LOAD = 4'(MUL_CYCLES - 1);

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d, opb_q, opb_d;
    logic [31:0] res_q, res_d;
    logic        id_q, id_d;
    logic [15:0] ops_q, ops_d;
    logic        grant;
    logic [31:0] core_p;

    // opa_q/opb_q -> res_q is a MUL_CYCLES multicycle path through the core.
    fp_mul32 u_mul (
        .a (opa_q),
        .b (opb_q),
        .p (core_p)
    );

    assign grant = (&req_valid) ? rr_q : req_valid[1];

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        res_d     = res_q;
        id_d      = id_q;
        ops_d     = ops_q;
        req_ready = 2'b00;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant ? 2'b10 : 2'b01;
                    opa_d     = grant ? req_a1 : req_a0;
                    opb_d     = grant ? req_b1 : req_b0;
                    id_d      = grant;
                    rr_d      = ~grant;
                    cnt_d     = CNT_LOAD;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_d   = core_p;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    ops_d   = ops_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= 4'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            res_q   <= 32'd0;
            id_q    <= 1'b0;
            ops_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            id_q    <= id_d;
            ops_q   <= ops_d;
        end
    end

    assign res_valid = (state_q == DONE);
    assign res_data  = res_q;
    assign res_id    = id_q;
    assign res_flags = fp_flags(res_q);
    assign op_count  = ops_q;

endmodule

// File: tb/tb_fpm_scheduler.sv
// Scoreboard bench for fpm_scheduler: operand queues per requester, a grant
// model, and an expected-result queue checked whenever res_valid is high.
module tb_fpm_scheduler;

    localparam int MC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_id;
    logic [2:0]  res_flags;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    fpm_scheduler #(.MUL_CYCLES(MC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_flags (res_flags),
        .op_count  (op_count)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
        logic [2:0]  f;
    } vec_t;

    typedef struct packed {
        logic        id;
        logic [31:0] p;
        logic [2:0]  f;
    } exp_t;

    vec_t src0[$];
    vec_t src1[$];
    exp_t sb[$];

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          grant_cyc = 0;
    int          r0_rises = 0;
    logic        busy = 1'b0;
    logic        rr_m = 1'b0;
    logic        seen_vld = 1'b0;
    logic [15:0] ops_m = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        req_valid = 2'b00;
        req_a0 = 32'd0; req_b0 = 32'd0;
        req_a1 = 32'd0; req_b1 = 32'd0;
        if (src0.size() != 0) begin
            req_valid[0] = 1'b1;
            req_a0 = src0[0].a;
            req_b0 = src0[0].b;
        end
        if (src1.size() != 0) begin
            req_valid[1] = 1'b1;
            req_a1 = src1[0].a;
            req_b1 = src1[0].b;
        end
    endtask

    // One clock: check at the negedge, advance the sources just after posedge.
    task automatic step();
        logic [1:0] exp_rdy;
        logic       g;
        exp_t       e;
        @(negedge clk);
        exp_rdy = 2'b00;
        if (!busy && (req_valid != 2'b00)) begin
            g = (&req_valid) ? rr_m : req_valid[1];
            exp_rdy = g ? 2'b10 : 2'b01;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (req_ready[0]) r0_rises++;

        if (res_valid) begin
            if (sb.size() == 0) begin
                chk("res_spurious", 32'(res_valid), 32'd0);
            end else begin
                if (!seen_vld) begin
                    chk("latency", 32'(cyc - grant_cyc), 32'(MC + 1));
                    seen_vld = 1'b1;
                end
                chk("res_data", res_data, sb[0].p);
                chk("res_id", 32'(res_id), 32'(sb[0].id));
                chk("res_flags", 32'(res_flags), 32'(sb[0].f));
                chk("op_count", 32'(op_count), 32'(ops_m));
                if (res_ready) begin
                    void'(sb.pop_front());
                    busy  = 1'b0;
                    ops_m = ops_m + 16'd1;
                end
            end
        end else if (busy && seen_vld) begin
            chk("res_valid_drop", 32'(res_valid), 32'd1);
        end

        if (exp_rdy != 2'b00) begin
            e.id = exp_rdy[1];
            e.p  = exp_rdy[1] ? src1[0].p : src0[0].p;
            e.f  = exp_rdy[1] ? src1[0].f : src0[0].f;
            sb.push_back(e);
            busy      = 1'b1;
            rr_m      = ~exp_rdy[1];
            grant_cyc = cyc;
            seen_vld  = 1'b0;
        end

        @(posedge clk);
        #1;
        if (exp_rdy[0]) void'(src0.pop_front());
        if (exp_rdy[1]) void'(src1.pop_front());
        drive();
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((src0.size() != 0 || src1.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(src0.size() + src1.size() + int'(busy)), 32'd0);
    endtask

    task automatic chk_reset();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_flags", 32'(res_flags), 32'd1);
        chk("rst_op_count", 32'(op_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        res_ready = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        rst = 1'b0;

        // Single request from requester 0: 2.0 * 9.0
        src0.push_back('{32'h4000_0000, 32'h4110_0000, 32'h4190_0000, 3'b000});
        drive();
        drain(50);
        chk("op_count_single", 32'(op_count), 32'd1);

        // Reset in the second CALC cycle discards the operation
        src0.push_back('{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000});
        drive();
        n = 0;
        while (!busy && n < 20) begin
            step();
            n++;
        end
        step();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset();
        rst = 1'b0;
        sb.delete();
        busy     = 1'b0;
        rr_m     = 1'b0;
        ops_m    = 16'd0;
        seen_vld = 1'b0;

        // Both valid from reset: requester 0 first, then 1; rr returns to 0
        src0.push_back('{32'h411C_0000, 32'h3F10_0000, 32'h40AF_8000, 3'b000});
        src1.push_back('{32'h4000_0000, 32'h4110_0000, 32'h4190_0000, 3'b000});
        drive();
        drain(50);
        src0.push_back('{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000});
        src1.push_back('{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 3'b000});
        drive();
        drain(50);

        // Requester 1 streams; requester 0 must never see ready
        r0_rises = 0;
        for (int i = 0; i < 4; i++) begin
            src1.push_back('{32'h4000_0000, 32'h4110_0000, 32'h4190_0000, 3'b000});
        end
        drive();
        drain(100);
        chk("r0_never_ready", 32'(r0_rises), 32'd0);

        // Special values: inf*0 -> all-ones NaN, 0*1.58 -> +0
        src0.push_back('{32'h7F80_0000, 32'h0000_0000, 32'hFFFF_FFFF, 3'b100});
        src0.push_back('{32'h0000_0000, 32'h3FCA_3D71, 32'h0000_0000, 3'b001});
        drive();
        drain(50);

        // Backpressure: 5 DONE cycles with res_ready low, requester 1 pending
        res_ready = 1'b0;
        src0.push_back('{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 3'b000});
        src1.push_back('{32'h3FC0_0000, 32'h3F80_0001, 32'h3FC0_0002, 3'b000});
        drive();
        n = 0;
        while (!(busy && seen_vld) && n < 20) begin
            step();
            n++;
        end
        repeat (4) step();
        chk("bp_op_count", 32'(op_count), 32'(ops_m));
        res_ready = 1'b1;
        drain(50);

        // Overflow to inf, NaN operand, underflow to zero
        src0.push_back('{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b010});
        src1.push_back('{32'h7FC0_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 3'b100});
        src0.push_back('{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b001});
        drive();
        drain(100);
        chk("op_count_final", 32'(op_count), 32'(ops_m));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
